pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 92 +++++++++
 tb/tb_pipe_skid_reg.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register: full throughput with in_ready and out_* all driven from flops.
// Latency 1 cycle into EMPTY; backpressure holds out_data stable, in_ready drops when both entries are occupied.
module pipe_skid_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             in_fire;
    logic             out_fire;

    always_comb begin
        in_fire  = in_valid & in_ready_q;
        out_fire = out_valid_q & out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_q      <= RESET_VAL;
            skid_q      <= RESET_VAL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            // A consumer handshake in this cycle still counts; data registers are left as-is.
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_q      <= in_data;
                        state_q     <= ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        skid_q     <= in_data;
                        state_q    <= FULL;
                        in_ready_q <= 1'b0;
                    end else if (out_fire) begin
                        state_q     <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_q     <= skid_q;
                        state_q    <= ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed vector table, streaming sequence, random run vs queue model.
module tb_pipe_skid_reg;

    logic       clk = 1'b0;
    logic       rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data, out_data;
    logic [1:0] occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mq[$];
    logic [7:0] m_head;
    bit         m_check = 1'b0;

    always #5 clk = ~clk;

    pipe_skid_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance one clock; the queue model consumes the same pre-edge inputs.
    task automatic tick();
        bit  ifire, ofire;
        ifire = in_valid && (mq.size() < 2);
        ofire = out_ready && (mq.size() > 0);
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            m_head = 8'hA5;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (ofire) void'(mq.pop_front());
            if (ifire) mq.push_back(in_data);
        end
        if (mq.size() > 0) m_head = mq[0];
        if (m_check) begin
            chk("rnd_out_valid", 32'(out_valid), 32'(mq.size() > 0));
            chk("rnd_in_ready",  32'(in_ready),  32'(mq.size() < 2));
            chk("rnd_occupancy", 32'(occupancy), 32'(mq.size()));
            chk("rnd_out_data",  32'(out_data),  32'(m_head));
        end
    endtask

    typedef struct {
        logic       rst, flush, iv;
        logic [7:0] din;
        logic       ordy;
        logic       eov, eir;
        logic [1:0] eocc;
        logic [7:0] edat;
    } vec_t;

    vec_t tbl[20];

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        m_head = 8'hA5;

        //           rst flush iv  din    ordy ov ir occ  data
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 8'hA5};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 2'd1, 8'h11};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 2'd2, 8'h11};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 2'd2, 8'h11};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 2'd1, 8'h22};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 2'd2, 8'h22};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'd1, 8'h33};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd0, 8'h33};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 2'd1, 8'h44};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 2'd2, 8'h44};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 2'd0, 8'h44};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd0, 8'h44};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 2'd1, 8'h77};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 8'h88, 1'b1, 1'b0, 1'b1, 2'd0, 8'hA5};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 2'd1, 8'h01};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 2'd2, 8'h01};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 8'hA5};
        tbl[17] = '{1'b0, 1'b0, 1'b1, 8'h99, 1'b0, 1'b1, 1'b1, 2'd1, 8'h99};
        tbl[18] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd0, 8'h99};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 8'h99};

        #1;
        foreach (tbl[i]) begin
            rst = tbl[i].rst; flush = tbl[i].flush; in_valid = tbl[i].iv;
            in_data = tbl[i].din; out_ready = tbl[i].ordy;
            tick();
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].eov));
            chk($sformatf("vec%0d_in_ready", i),  32'(in_ready),  32'(tbl[i].eir));
            chk($sformatf("vec%0d_occupancy", i), 32'(occupancy), 32'(tbl[i].eocc));
            chk($sformatf("vec%0d_out_data", i),  32'(out_data),  32'(tbl[i].edat));
        end
        rst = 1'b0; flush = 1'b0;

        // Streaming at full rate: each word shows up one cycle after it is offered.
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            in_data = 8'(k);
            tick();
            chk("stream_out_data",  32'(out_data),  32'(k));
            chk("stream_occupancy", 32'(occupancy), 32'd1);
            chk("stream_in_ready",  32'(in_ready),  32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain_occ", 32'(occupancy), 32'd0);

        // Random traffic against the queue model.
        m_check = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            logic ir_a;
            rst       = ($urandom_range(0, 499) == 0);
            flush     = ($urandom_range(0, 99) == 0);
            in_valid  = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 2) != 0;
            in_data   = 8'($urandom);
            if (c % 50 == 0) begin
                ir_a = in_ready;
                out_ready = ~out_ready;
                #1;
                chk("in_ready_vs_out_ready", 32'(in_ready), 32'(ir_a));
                out_ready = ~out_ready;
                #1;
            end
            tick();
        end
        m_check = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
